picobus_wishbone_bridge_gen2: RTL and testbench

- Parametrised second-generation bridge from the PicoRV32 native memory bus to a Wishbone B4 classic master port.
- Adds over the first generation: configurable address decode and Wishbone address width; Wishbone RTY handling with bounded retry; a per-attempt response timeout that converts a hung slave into a bus error; a clean one-cycle ready pulse.
- Sits between the CPU memory interface and the peripheral Wishbone interconnect.

---
 rtl/picobus_wishbone_bridge_gen2.sv | 176 +++++++++++++++++
 tb/tb_picobus_wishbone_bridge_gen2.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/picobus_wishbone_bridge_gen2.sv
// PicoRV32 native bus to Wishbone B4 classic master bridge.
// Handles address decode, RTY with bounded retry, and a per-attempt response timeout.
module picobus_wishbone_bridge_gen2 #(
  parameter logic [31:0] DEC_BASE  = 32'h4500_0000,
  parameter logic [31:0] DEC_MASK  = 32'hFF00_0000,
  parameter int          WB_ADR_W  = 22,
  parameter int          TIMEOUT   = 255,
  parameter int          MAX_RETRY = 3
) (
  input  logic                in_clock,
  input  logic                in_reset_n,
  input  logic                in_pico_valid,
  input  logic [31:0]         in_pico_address,
  input  logic [3:0]          in_pico_wstrobe,
  input  logic [31:0]         in_pico_wdata,
  output logic                out_pico_ready,
  output logic                out_pico_error,
  output logic [31:0]         out_pico_rdata,
  output logic                out_wb_cyc,
  output logic                out_wb_stb,
  output logic                out_wb_we,
  output logic [WB_ADR_W-1:0] out_wb_adr,
  output logic [3:0]          out_wb_sel,
  output logic [31:0]         out_wb_wdat,
  input  logic                in_wb_ack,
  input  logic                in_wb_err,
  input  logic                in_wb_rty,
  input  logic [31:0]         in_wb_rdat,
  output logic                out_busy
);

  // A zero-width counter is illegal, so disabled features still get one bit.
  localparam int TMO_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = (TIMEOUT > 0) ? TMO_W'(TIMEOUT - 1) : '0;
  localparam logic [RTY_W-1:0] RTY_LAST = RTY_W'(MAX_RETRY);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_BACKOFF, S_RESP} state_e;

  state_e                state_q, state_d;
  logic                  cyc_q, cyc_d, stb_q, stb_d, we_q, we_d;
  logic [WB_ADR_W-1:0]   adr_q, adr_d;
  logic [3:0]            sel_q, sel_d;
  logic [31:0]           wdat_q, wdat_d, rdata_q, rdata_d;
  logic                  ready_q, ready_d, error_q, error_d, busy_q, busy_d;
  logic [TMO_W-1:0]      tmo_q, tmo_d;
  logic [RTY_W-1:0]      rty_q, rty_d;
  logic                  claim;

  assign claim = in_pico_valid && ((in_pico_address & DEC_MASK) == DEC_BASE);

  always_ff @(posedge in_clock or negedge in_reset_n) begin
    if (!in_reset_n) begin
      state_q <= S_IDLE;
      cyc_q   <= 1'b0;
      stb_q   <= 1'b0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      sel_q   <= '0;
      wdat_q  <= '0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      error_q <= 1'b0;
      busy_q  <= 1'b0;
      tmo_q   <= '0;
      rty_q   <= '0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      stb_q   <= stb_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      sel_q   <= sel_d;
      wdat_q  <= wdat_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      error_q <= error_d;
      busy_q  <= busy_d;
      tmo_q   <= tmo_d;
      rty_q   <= rty_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    stb_d   = stb_q;
    we_d    = we_q;
    adr_d   = adr_q;
    sel_d   = sel_q;
    wdat_d  = wdat_q;
    rdata_d = rdata_q;
    ready_d = 1'b0;
    error_d = 1'b0;
    tmo_d   = tmo_q;
    rty_d   = rty_q;
    case (state_q)
      S_IDLE: begin
        if (claim) begin
          state_d = S_REQ;
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
          we_d    = |in_pico_wstrobe;
          sel_d   = (|in_pico_wstrobe) ? in_pico_wstrobe : 4'hF;
          adr_d   = in_pico_address[WB_ADR_W+1:2];
          wdat_d  = in_pico_wdata;
          tmo_d   = '0;
          rty_d   = '0;
        end
      end
      S_REQ: begin
        // ack > err > rty > timeout; any real response beats a coincident timeout.
        if (in_wb_ack) begin
          state_d = S_RESP;
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          ready_d = 1'b1;
          if (!we_q) rdata_d = in_wb_rdat;
        end else if (in_wb_err) begin
          state_d = S_RESP;
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          ready_d = 1'b1;
          error_d = 1'b1;
          rdata_d = '0;
        end else if (in_wb_rty) begin
          cyc_d = 1'b0;
          stb_d = 1'b0;
          if (rty_q < RTY_LAST) begin
            state_d = S_BACKOFF;
            rty_d   = rty_q + 1'b1;
          end else begin
            state_d = S_RESP;
            ready_d = 1'b1;
            error_d = 1'b1;
            rdata_d = '0;
          end
        end else if ((TIMEOUT != 0) && (tmo_q == TMO_LAST)) begin
          state_d = S_RESP;
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          ready_d = 1'b1;
          error_d = 1'b1;
          rdata_d = '0;
        end else if (tmo_q != '1) begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_BACKOFF: begin
        state_d = S_REQ;
        cyc_d   = 1'b1;
        stb_d   = 1'b1;
        tmo_d   = '0;
      end
      S_RESP: begin
        state_d = S_IDLE;
        tmo_d   = '0;
        rty_d   = '0;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  assign out_pico_ready = ready_q;
  assign out_pico_error = error_q;
  assign out_pico_rdata = rdata_q;
  assign out_wb_cyc     = cyc_q;
  assign out_wb_stb     = stb_q;
  assign out_wb_we      = we_q;
  assign out_wb_adr     = adr_q;
  assign out_wb_sel     = sel_q;
  assign out_wb_wdat    = wdat_q;
  assign out_busy       = busy_q;

endmodule

// File: tb/tb_picobus_wishbone_bridge_gen2.sv
// Directed bench for the PicoRV32-to-Wishbone bridge: decode, ack/err, retry, timeout, async reset.
module tb_picobus_wishbone_bridge_gen2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid, valid2;
  logic [31:0] addr, wdata, rdat;
  logic [3:0]  wstrb;
  logic        ack, err, rty;
  logic        ready, error, cyc, stb, we, busy;
  logic [31:0] rdata, wdat;
  logic [21:0] adr;
  logic [3:0]  sel;
  logic        ready2, error2, cyc2, stb2, we2, busy2;
  logic [31:0] rdata2, wdat2;
  logic [21:0] adr2;
  logic [3:0]  sel2;

  int checks = 0;
  int errs   = 0;

  always #5 clk = ~clk;

  picobus_wishbone_bridge_gen2 #(.TIMEOUT(8), .MAX_RETRY(3)) dut (
    .in_clock(clk), .in_reset_n(rst_n),
    .in_pico_valid(valid), .in_pico_address(addr), .in_pico_wstrobe(wstrb), .in_pico_wdata(wdata),
    .out_pico_ready(ready), .out_pico_error(error), .out_pico_rdata(rdata),
    .out_wb_cyc(cyc), .out_wb_stb(stb), .out_wb_we(we), .out_wb_adr(adr), .out_wb_sel(sel),
    .out_wb_wdat(wdat), .in_wb_ack(ack), .in_wb_err(err), .in_wb_rty(rty), .in_wb_rdat(rdat),
    .out_busy(busy)
  );

  // Timeout disabled, slave permanently silent.
  picobus_wishbone_bridge_gen2 #(.TIMEOUT(0), .MAX_RETRY(3)) dut_notmo (
    .in_clock(clk), .in_reset_n(rst_n),
    .in_pico_valid(valid2), .in_pico_address(addr), .in_pico_wstrobe(wstrb), .in_pico_wdata(wdata),
    .out_pico_ready(ready2), .out_pico_error(error2), .out_pico_rdata(rdata2),
    .out_wb_cyc(cyc2), .out_wb_stb(stb2), .out_wb_we(we2), .out_wb_adr(adr2), .out_wb_sel(sel2),
    .out_wb_wdat(wdat2), .in_wb_ack(1'b0), .in_wb_err(1'b0), .in_wb_rty(1'b0), .in_wb_rdat(32'h0),
    .out_busy(busy2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the claim edge.
  task automatic issue(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
    valid = 1'b1; addr = a; wstrb = s; wdata = d;
    @(negedge clk);
  endtask

  // Present a slave response for one cycle; returns after the DUT sampled it.
  task automatic resp(input logic a, input logic e, input logic r, input logic [31:0] d);
    ack = a; err = e; rty = r; rdat = d;
    @(negedge clk);
    ack = 1'b0; err = 1'b0; rty = 1'b0; rdat = 32'h0;
  endtask

  task automatic finish_access();
    valid = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen, n, k;
    rst_n = 1'b0; valid = 1'b0; valid2 = 1'b0;
    addr = '0; wstrb = '0; wdata = '0;
    ack = 1'b0; err = 1'b0; rty = 1'b0; rdat = '0;
    repeat (2) @(negedge clk);
    chk("rst cyc", 32'(cyc), 0);
    chk("rst stb", 32'(stb), 0);
    chk("rst ready", 32'(ready), 0);
    chk("rst busy", 32'(busy), 0);
    chk("rst rdata", rdata, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Read with a 3-cycle slave wait.
    issue(32'h4500_0010, 4'h0, 32'h0);
    chk("rd cyc", 32'(cyc), 1);
    chk("rd stb", 32'(stb), 1);
    chk("rd adr", 32'(adr), 32'h4);
    chk("rd sel", 32'(sel), 32'hF);
    chk("rd we", 32'(we), 0);
    chk("rd busy", 32'(busy), 1);
    repeat (2) @(negedge clk);
    chk("rd stb hold", 32'(stb), 1);
    chk("rd no early ready", 32'(ready), 0);
    resp(1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF);
    chk("rd ready", 32'(ready), 1);
    chk("rd error", 32'(error), 0);
    chk("rd rdata", rdata, 32'hDEAD_BEEF);
    chk("rd cyc in resp", 32'(cyc), 0);
    chk("rd busy in resp", 32'(busy), 1);
    finish_access();
    chk("rd ready pulse", 32'(ready), 0);
    chk("rd busy fall", 32'(busy), 0);

    // Write acked on the first strobe cycle: ready two edges after valid.
    issue(32'h4512_3458, 4'b0110, 32'hA5A5_5A5A);
    chk("wr we", 32'(we), 1);
    chk("wr sel", 32'(sel), 32'h6);
    chk("wr adr", 32'(adr), 32'h48D16);
    chk("wr wdat", wdat, 32'hA5A5_5A5A);
    resp(1'b1, 1'b0, 1'b0, 32'h1111_1111);
    chk("wr ready", 32'(ready), 1);
    chk("wr error", 32'(error), 0);
    chk("wr rdata kept", rdata, 32'hDEAD_BEEF);
    finish_access();

    // Unclaimed address.
    valid = 1'b1; addr = 32'h1000_0000; wstrb = 4'h0;
    seen = 0;
    repeat (50) begin
      @(negedge clk);
      if (cyc || ready || busy) seen = 1;
    end
    chk("unclaimed", 32'(seen), 0);
    valid = 1'b0;
    @(negedge clk);

    // Simultaneous ack+err: ack wins.
    issue(32'h4500_0100, 4'h0, 32'h0);
    resp(1'b1, 1'b1, 1'b0, 32'hCAFE_F00D);
    chk("ackerr ready", 32'(ready), 1);
    chk("ackerr error", 32'(error), 0);
    chk("ackerr rdata", rdata, 32'hCAFE_F00D);
    finish_access();

    // Four RTYs exceed MAX_RETRY=3.
    issue(32'h4500_0020, 4'h0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      resp(1'b0, 1'b0, 1'b1, 32'h0);
      chk("rty4 backoff cyc", 32'(cyc), 0);
      @(negedge clk);
      chk("rty4 rereq stb", 32'(stb), 1);
    end
    resp(1'b0, 1'b0, 1'b1, 32'h0);
    chk("rty4 ready", 32'(ready), 1);
    chk("rty4 error", 32'(error), 1);
    chk("rty4 rdata", rdata, 32'h0);
    finish_access();

    // Three RTYs then ack: each backoff is one cycle.
    issue(32'h4500_0024, 4'h0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      resp(1'b0, 1'b0, 1'b1, 32'h0);
      chk("rty3 backoff cyc", 32'(cyc), 0);
      chk("rty3 backoff stb", 32'(stb), 0);
      chk("rty3 no ready", 32'(ready), 0);
      @(negedge clk);
      chk("rty3 rereq cyc", 32'(cyc), 1);
      chk("rty3 rereq adr", 32'(adr), 32'h9);
    end
    resp(1'b1, 1'b0, 1'b0, 32'h1234_5678);
    chk("rty3 ready", 32'(ready), 1);
    chk("rty3 error", 32'(error), 0);
    chk("rty3 rdata", rdata, 32'h1234_5678);
    finish_access();

    // Silent slave with TIMEOUT=8.
    issue(32'h4500_0030, 4'h0, 32'h0);
    n = 0; k = 0;
    while (!ready && k < 30) begin
      if (stb) n++;
      @(negedge clk);
      k++;
    end
    chk("tmo stb cycles", 32'(n), 8);
    chk("tmo ready", 32'(ready), 1);
    chk("tmo error", 32'(error), 1);
    chk("tmo rdata", rdata, 32'h0);
    finish_access();

    // TIMEOUT=0 never gives up.
    addr = 32'h4500_0040; wstrb = 4'h0; valid2 = 1'b1;
    seen = 0;
    repeat (1000) begin
      @(negedge clk);
      if (ready2) seen = 1;
    end
    valid2 = 1'b0;
    chk("notmo ready", 32'(seen), 0);
    chk("notmo busy", 32'(busy2), 1);
    chk("notmo stb", 32'(stb2), 1);

    // Asynchronous reset in the middle of REQ.
    issue(32'h4500_0050, 4'h0, 32'h0);
    chk("arst pre stb", 32'(stb), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst cyc", 32'(cyc), 0);
    chk("arst stb", 32'(stb), 0);
    chk("arst busy", 32'(busy), 0);
    valid = 1'b0;
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (ready) seen = 1;
    end
    rst_n = 1'b1;
    @(negedge clk);
    if (ready) seen = 1;
    chk("arst no ready", 32'(seen), 0);
    issue(32'h4500_0060, 4'h0, 32'h0);
    resp(1'b1, 1'b0, 1'b0, 32'h0BAD_C0DE);
    chk("post rst ready", 32'(ready), 1);
    chk("post rst error", 32'(error), 0);
    chk("post rst rdata", rdata, 32'h0BAD_C0DE);
    finish_access();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
